// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage driving a req/ack data-memory port
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] pc,
    input  logic [31:0] insn,
    input  logic [31:0] alu_out,
    input  logic [31:0] rt_val,
    input  logic        dm_we,
    input  logic        r_we,
    input  logic [1:0]  r_dst,
    input  logic [1:0]  rw_d,
    input  logic [1:0]  mem_read_size,
    input  logic        mem_sign_extend,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [31:0] pc_out,
    output logic [31:0] insn_out,
    output logic        r_we_out,
    output logic [1:0]  r_dst_out,
    output logic [1:0]  rw_d_out,
    output logic [31:0] alu_out_reg,
    output logic [31:0] mem_data_out,
`ifdef DMEM_TIMEOUT_EN
    output logic        bus_err,
`endif
    output logic        addr_err
);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;

    logic        mem_op, aligned, issue, misalign, ack_hit, timeout, done;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;
    logic [7:0]  lane;
    logic [15:0] half;

    logic [31:0] h_pc, h_insn, h_alu;
    logic        h_r_we, h_sext, h_we;
    logic [1:0]  h_r_dst, h_rw_d, h_size;

    assign mem_op   = in_valid & (dm_we | (rw_d == 2'd1));
    assign issue    = (state == IDLE) & mem_op & aligned;
    assign misalign = mem_op & ~aligned;
    assign ack_hit  = (state == BUSY) & dmem_req & dmem_ack;
    assign done     = ack_hit | timeout;

    always_comb begin
        case (mem_read_size)
            2'd1:    aligned = ~alu_out[0];
            2'd2:    aligned = 1'b1;
            default: aligned = (alu_out[1:0] == 2'b00);
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] busy_cnt;

    assign timeout = (state == BUSY) & (busy_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) busy_cnt <= '0;
        else                         busy_cnt <= busy_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = rt_val;
        case (mem_read_size)
            2'd1: begin
                st_be    = alu_out[1] ? 4'b0011 : 4'b1100;
                st_wdata = {2{rt_val[15:0]}};
            end
            2'd2: begin
                st_be    = 4'b1000 >> alu_out[1:0];
                st_wdata = {4{rt_val[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane = 8'(dmem_rdata >> {~h_alu[1:0], 3'b000});
        half = h_alu[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        case (h_size)
            2'd1:    ld_data = {{16{h_sext & half[15]}}, half};
            2'd2:    ld_data = {{24{h_sext & lane[7]}}, lane};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            IDLE: if (issue) begin
                stall    = 1'b1;
                state_nx = BUSY;
            end
            BUSY: begin
                stall = ~done;
                if (done) state_nx = IDLE;
            end
        endcase
        if (!rst_n) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            out_valid    <= 1'b0;
            pc_out       <= '0;
            insn_out     <= '0;
            r_we_out     <= 1'b0;
            r_dst_out    <= '0;
            rw_d_out     <= '0;
            alu_out_reg  <= '0;
            mem_data_out <= '0;
            addr_err     <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            bus_err      <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            addr_err  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            bus_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    dmem_be  <= 4'b0000;
                    if (issue) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= dm_we;
                        dmem_addr  <= {alu_out[31:2], 2'b00};
                        dmem_be    <= st_be;
                        dmem_wdata <= st_wdata;
                        h_pc       <= pc;
                        h_insn     <= insn;
                        h_alu      <= alu_out;
                        h_r_we     <= r_we;
                        h_r_dst    <= r_dst;
                        h_rw_d     <= rw_d;
                        h_size     <= mem_read_size;
                        h_sext     <= mem_sign_extend;
                        h_we       <= dm_we;
                    end else if (in_valid) begin
                        out_valid    <= 1'b1;
                        pc_out       <= pc;
                        insn_out     <= insn;
                        r_we_out     <= r_we & ~misalign;
                        r_dst_out    <= r_dst;
                        rw_d_out     <= rw_d;
                        alu_out_reg  <= alu_out;
                        mem_data_out <= '0;
                        addr_err     <= misalign;
                    end
                end
                BUSY: if (done) begin
                    dmem_req     <= 1'b0;
                    dmem_we      <= 1'b0;
                    dmem_be      <= 4'b0000;
                    out_valid    <= 1'b1;
                    pc_out       <= h_pc;
                    insn_out     <= h_insn;
                    r_we_out     <= h_r_we & ack_hit;
                    r_dst_out    <= h_r_dst;
                    rw_d_out     <= h_rw_d;
                    alu_out_reg  <= h_alu;
                    mem_data_out <= (ack_hit & ~h_we) ? ld_data : 32'h0;
`ifdef DMEM_TIMEOUT_EN
                    bus_err      <= ~ack_hit;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, dm_we, r_we, mem_sign_extend, dmem_ack;
    logic [31:0] pc, insn, alu_out, rt_val, dmem_rdata;
    logic [1:0]  r_dst, rw_d, mem_read_size;
    logic        stall, dmem_req, dmem_we, out_valid, r_we_out, addr_err;
    logic [31:0] dmem_addr, dmem_wdata, pc_out, insn_out, alu_out_reg, mem_data_out;
    logic [3:0]  dmem_be;
    logic [1:0]  r_dst_out, rw_d_out;
`ifdef DMEM_TIMEOUT_EN
    logic        bus_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc(pc), .insn(insn),
        .alu_out(alu_out), .rt_val(rt_val), .dm_we(dm_we), .r_we(r_we), .r_dst(r_dst),
        .rw_d(rw_d), .mem_read_size(mem_read_size), .mem_sign_extend(mem_sign_extend),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .pc_out(pc_out),
        .insn_out(insn_out), .r_we_out(r_we_out), .r_dst_out(r_dst_out),
        .rw_d_out(rw_d_out), .alu_out_reg(alu_out_reg), .mem_data_out(mem_data_out),
`ifdef DMEM_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .addr_err(addr_err)
    );

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 4 : ((sz == 2'd1) ? 2 : 1);
    endfunction

    function automatic logic m_aligned(input logic [31:0] a, input logic [1:0] sz);
        return (a % nbytes(sz)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
        logic [3:0] be = '0;
        for (int i = 0; i < nbytes(sz); i++) be[3 - (int'(a % 4) + i)] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] rt, input logic [1:0] sz);
        int n = nbytes(sz);
        logic [63:0] unit = {32'h0, rt} & ((64'd1 << (8 * n)) - 1);
        logic [63:0] w = '0;
        for (int i = 0; i < 4 / n; i++) w = (w << (8 * n)) | unit;
        return w[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sx);
        int n = nbytes(sz);
        int k = int'(a % 4);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | ({32'h0, rd} >> (24 - 8 * (k + i)) & 64'hFF);
        if (sx && n < 4 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic run_txn(input logic we, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] rt, input int waits,
                           input logic [31:0] rd, input logic [31:0] pcv,
                           output int n_stall, output int n_req, output int n_ov, output int n_aerr,
                           output logic [31:0] g_addr, output logic [3:0] g_be,
                           output logic [31:0] g_wdata, output logic g_we,
                           output logic [31:0] g_data, output logic g_rwe,
                           output logic [31:0] g_pc, output logic done);
        int post = 0;
        logic consumed = 1'b0;
        n_stall = 0; n_req = 0; n_ov = 0; n_aerr = 0;
        g_addr = '0; g_be = '0; g_wdata = '0; g_we = 1'b0; g_data = '0; g_rwe = 1'b0; g_pc = '0;
        in_valid = 1'b1; pc = pcv; insn = $urandom; alu_out = a; rt_val = rt;
        dm_we = we; r_we = ~we; r_dst = 2'($urandom_range(0, 2)); rw_d = we ? 2'd0 : 2'd1;
        mem_read_size = sz; mem_sign_extend = sx;
        for (int c = 0; c < 60 && post < 3; c++) begin
            dmem_ack = 1'b0;
            if (dmem_req) begin
                g_addr = dmem_addr; g_be = dmem_be; g_wdata = dmem_wdata; g_we = dmem_we;
                if (n_req == waits) begin dmem_ack = 1'b1; dmem_rdata = rd; end
                else dmem_rdata = $urandom;
                n_req++;
            end
            #1;
            if (stall) n_stall++;
            if (out_valid) begin n_ov++; g_data = mem_data_out; g_rwe = r_we_out; g_pc = pc_out; end
            if (addr_err) n_aerr++;
            if (consumed) post++;
            else if (!stall) consumed = 1'b1;
            @(negedge clk);
            if (consumed) begin in_valid = 1'b0; dmem_ack = 1'b0; end
        end
        dmem_ack = 1'b0;
        in_valid = 1'b0;
        done = consumed;
    endtask

    int          n_stall, n_req, n_ov, n_aerr;
    logic [31:0] g_addr, g_wdata, g_data, g_pc;
    logic [3:0]  g_be;
    logic        g_we, g_rwe, done;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({stall, dmem_req, dmem_be, out_valid, addr_err} !== 8'h00) begin errors++;
            $display("FAIL reset_ctrl: got %h want 00", {stall, dmem_req, dmem_be, out_valid, addr_err}); end
        checks++; if ({mem_data_out, alu_out_reg, pc_out} !== 96'h0) begin errors++;
            $display("FAIL reset_data: got %h want 0", {mem_data_out, alu_out_reg, pc_out}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        run_txn(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 32'h400,
                n_stall, n_req, n_ov, n_aerr, g_addr, g_be, g_wdata, g_we, g_data, g_rwe, g_pc, done);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lw_done: got %b want 1", done); end
        checks++; if (n_stall != 4) begin errors++; $display("FAIL lw_stall: got %0d want 4", n_stall); end
        checks++; if ({g_addr, g_be} !== {32'h100, 4'b1111}) begin errors++;
            $display("FAIL lw_req: got %h/%b want 100/1111", g_addr, g_be); end
        checks++; if (g_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", g_data); end
        checks++; if (n_ov != 1) begin errors++; $display("FAIL lw_ovcount: got %0d want 1", n_ov); end
    endtask

    task automatic test_lb();
        run_txn(1'b0, 2'd2, 1'b1, 32'h101, 32'h0, 1, 32'h11803344, 32'h404,
                n_stall, n_req, n_ov, n_aerr, g_addr, g_be, g_wdata, g_we, g_data, g_rwe, g_pc, done);
        checks++; if (g_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", g_data); end
        run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h11803344, 32'h408,
                n_stall, n_req, n_ov, n_aerr, g_addr, g_be, g_wdata, g_we, g_data, g_rwe, g_pc, done);
        checks++; if (g_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h want 00000080", g_data); end
        checks++; if (g_be !== 4'b0100) begin errors++; $display("FAIL lbu_be: got %b want 0100", g_be); end
    endtask

    task automatic test_sh();
        run_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 1, 32'h0, 32'h40C,
                n_stall, n_req, n_ov, n_aerr, g_addr, g_be, g_wdata, g_we, g_data, g_rwe, g_pc, done);
        checks++; if ({g_addr, g_be, g_wdata, g_we} !== {32'h200, 4'b0011, 32'hABCDABCD, 1'b1}) begin errors++;
            $display("FAIL sh_req: got %h/%b/%h/%b want 200/0011/abcdabcd/1", g_addr, g_be, g_wdata, g_we); end
        checks++; if ({g_rwe, g_data, n_ov} !== {1'b0, 32'h0, 32'd1}) begin errors++;
            $display("FAIL sh_wb: got rwe=%b data=%h ov=%0d want 0/0/1", g_rwe, g_data, n_ov); end
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h0, 32'h410,
                n_stall, n_req, n_ov, n_aerr, g_addr, g_be, g_wdata, g_we, g_data, g_rwe, g_pc, done);
        checks++; if ({n_req, n_stall} !== {32'd0, 32'd0}) begin errors++;
            $display("FAIL mis_noreq: got req=%0d stall=%0d want 0/0", n_req, n_stall); end
        checks++; if ({n_aerr, n_ov, g_rwe} !== {32'd1, 32'd1, 1'b0}) begin errors++;
            $display("FAIL mis_err: got aerr=%0d ov=%0d rwe=%b want 1/1/0", n_aerr, n_ov, g_rwe); end
    endtask

    task automatic test_alu_stray_ack();
        in_valid = 1'b1; dm_we = 1'b0; rw_d = 2'd0; r_we = 1'b1; alu_out = 32'h5;
        mem_read_size = 2'd0; dmem_ack = 1'b1; pc = 32'h500;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", stall); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if ({out_valid, alu_out_reg, r_we_out, dmem_req} !== {1'b1, 32'h5, 1'b1, 1'b0}) begin errors++;
            $display("FAIL alu_wb: got ov=%b alu=%h rwe=%b req=%b want 1/5/1/0", out_valid, alu_out_reg, r_we_out, dmem_req); end
        @(negedge clk);
        #1;
        checks++; if ({out_valid, dmem_req, stall} !== 3'b000) begin errors++;
            $display("FAIL stray_ack: got %b want 000", {out_valid, dmem_req, stall}); end
        dmem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        in_valid = 1'b1; dm_we = 1'b0; rw_d = 2'd1; r_we = 1'b1; alu_out = 32'h40; mem_read_size = 2'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rb_busy: got %b want 1", dmem_req); end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++; if ({dmem_req, out_valid} !== 2'b00) begin errors++;
            $display("FAIL rb_reset: got %b want 00", {dmem_req, out_valid}); end
        rst_n = 1'b1; in_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checks++; if ({dmem_req, out_valid, stall} !== 3'b000) begin errors++;
                $display("FAIL rb_late_ack: got %b want 000", {dmem_req, out_valid, stall}); end
        end
        dmem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a, rt, rd, pcv;
        logic [1:0]  sz;
        logic        we, sx, al;
        int          waits;
        for (int it = 0; it < 40; it++) begin
            sz = 2'($urandom_range(0, 2)); we = 1'($urandom_range(0, 1)); sx = 1'($urandom_range(0, 1));
            a = $urandom; rt = $urandom; rd = $urandom; pcv = $urandom; waits = $urandom_range(0, 4);
            if ($urandom_range(0, 2) != 0) a = a - (a % nbytes(sz));
            al = m_aligned(a, sz);
            run_txn(we, sz, sx, a, rt, waits, rd, pcv,
                    n_stall, n_req, n_ov, n_aerr, g_addr, g_be, g_wdata, g_we, g_data, g_rwe, g_pc, done);
            if (al) begin
                checks++; if ({g_addr, g_be, g_wdata, g_we} !== {a - (a % 4), m_be(a, sz), m_wdata(rt, sz), we}) begin errors++;
                    $display("FAIL rand_req[%0d]: got %h/%b/%h/%b want %h/%b/%h/%b", it, g_addr, g_be, g_wdata, g_we,
                             a - (a % 4), m_be(a, sz), m_wdata(rt, sz), we); end
                checks++; if ({g_data, g_rwe, g_pc} !== {we ? 32'h0 : m_load(rd, a, sz, sx), ~we, pcv}) begin errors++;
                    $display("FAIL rand_wb[%0d]: got %h/%b/%h want %h/%b/%h", it, g_data, g_rwe, g_pc,
                             we ? 32'h0 : m_load(rd, a, sz, sx), ~we, pcv); end
                checks++; if ({n_stall, n_req, n_ov, n_aerr} !== {waits + 1, waits + 1, 32'd1, 32'd0}) begin errors++;
                    $display("FAIL rand_cnt[%0d]: got stall=%0d req=%0d ov=%0d aerr=%0d want %0d/%0d/1/0", it,
                             n_stall, n_req, n_ov, n_aerr, waits + 1, waits + 1); end
            end else begin
                checks++; if ({n_stall, n_req, n_ov, n_aerr, 31'h0, g_rwe} !== {32'd0, 32'd0, 32'd1, 32'd1, 32'd0}) begin errors++;
                    $display("FAIL rand_mis[%0d]: got stall=%0d req=%0d ov=%0d aerr=%0d rwe=%b want 0/0/1/1/0", it,
                             n_stall, n_req, n_ov, n_aerr, g_rwe); end
            end
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int busy = 0;
        logic seen = 1'b0;
        in_valid = 1'b1; dm_we = 1'b0; rw_d = 2'd1; r_we = 1'b1; alu_out = 32'h300; mem_read_size = 2'd0;
        dmem_ack = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (bus_err) begin
                seen = 1'b1;
                checks++; if ({out_valid, r_we_out, dmem_req} !== 3'b100) begin errors++;
                    $display("FAIL to_wb: got %b want 100", {out_valid, r_we_out, dmem_req}); end
            end else if (dmem_req) busy++;
        end
        checks++; if ({seen, busy} !== {1'b1, 32'd4}) begin errors++;
            $display("FAIL to_cycles: got seen=%b busy=%0d want 1/4", seen, busy); end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; dm_we = 1'b0; r_we = 1'b0; mem_sign_extend = 1'b0;
        dmem_ack = 1'b0; pc = '0; insn = '0; alu_out = '0; rt_val = '0; dmem_rdata = '0;
        r_dst = '0; rw_d = '0; mem_read_size = '0;
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_misaligned();
        test_alu_stray_ack();
        test_reset_busy();
        test_random();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
